// File: rtl/encoder_pkg.sv
// Shared types and default constants for the rotary quadrature decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a; every consumer processes one sample per clock.
package encoder_pkg;

   // Classification of one sampled change on the {A,B} encoder pair
   typedef enum logic [1:0] {
      NONE    = 2'd0,
      CW      = 2'd1,
      CCW     = 2'd2,
      ILLEGAL = 2'd3
   } trans_e;

   localparam int DEF_COUNT_MAX        = 255;
   localparam int DEF_STEPS_PER_DETENT = 4;
   localparam int DEF_WRAP             = 1;

endpackage

// File: rtl/quad_step_classifier.sv
// Purpose: classifies the previous/current {A,B} pair as NONE, CW, CCW or ILLEGAL.
// Latency: purely combinational.
// Backpressure: none; a new pair is accepted on every cycle.
// Ports: i_prev_ab - registered {A,B} from the last cycle, i_ab - current {A,B},
//        o_trans - resulting transition class.
module quad_step_classifier
   import encoder_pkg::*;
(
   input  logic [1:0] i_prev_ab,
   input  logic [1:0] i_ab,
   output trans_e     o_trans
);

   // Gray sequence 00 -> 01 -> 11 -> 10 -> 00 is clockwise
   always_comb begin
      o_trans = NONE;
      case ({i_prev_ab, i_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: o_trans = CW;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: o_trans = CCW;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: o_trans = ILLEGAL;
         default:                                o_trans = NONE;
      endcase
   end

endmodule

// File: rtl/quadrature_decoder.sv
// Purpose: rotary encoder decoder - detent counter with direction, press and error pulses.
// Latency: all outputs registered, updated on the edge that samples the causing input.
// Backpressure: none; one encoder sample is consumed every clock.
// Ports: i_clk, i_rst (sync, active-high), i_enc_a/i_enc_b (idle high), i_enc_sw (active-low),
//        i_clr (count clear); o_count, o_step, o_dir (1 = CW), o_press, o_error.
module quadrature_decoder
   import encoder_pkg::*;
#(
   parameter int COUNT_MAX        = DEF_COUNT_MAX,
   parameter int STEPS_PER_DETENT = DEF_STEPS_PER_DETENT,
   parameter int WRAP             = DEF_WRAP
)(
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_enc_a,
   input  logic                           i_enc_b,
   input  logic                           i_enc_sw,
   input  logic                           i_clr,
   output logic [$clog2(COUNT_MAX+1)-1:0] o_count,
   output logic                           o_step,
   output logic                           o_dir,
   output logic                           o_press,
   output logic                           o_error
);

   localparam int CNT_W = $clog2(COUNT_MAX+1);
   localparam int ACC_W = 4;   // holds -4..+4 with sign

   localparam logic        [CNT_W-1:0] L_CNT_MAX = CNT_W'(COUNT_MAX);
   localparam logic signed [ACC_W-1:0] L_SPD     = ACC_W'(STEPS_PER_DETENT);
   localparam logic signed [ACC_W-1:0] L_ONE     = ACC_W'(1);

   logic        [1:0]       r_prev_ab;
   logic                    r_sw;
   logic signed [ACC_W-1:0] r_acc;
   logic        [CNT_W-1:0] r_count;
   logic                    r_step;
   logic                    r_dir;
   logic                    r_press;
   logic                    r_error;

   logic        [1:0]       w_ab;
   trans_e                  w_trans;
   logic signed [ACC_W-1:0] w_acc_up;
   logic signed [ACC_W-1:0] w_acc_dn;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic        [CNT_W-1:0] w_cnt_nxt;
   logic                    w_step_nxt;
   logic                    w_dir_nxt;

   assign w_ab     = {i_enc_a, i_enc_b};
   assign w_acc_up = r_acc + L_ONE;
   assign w_acc_dn = r_acc - L_ONE;

   quad_step_classifier u_cls (
      .i_prev_ab (r_prev_ab),
      .i_ab      (w_ab),
      .o_trans   (w_trans)
   );

   always_comb begin
      w_acc_nxt  = r_acc;
      w_cnt_nxt  = r_count;
      w_step_nxt = 1'b0;
      w_dir_nxt  = r_dir;
      if (i_clr) begin
         // Clear wins over a detent completing on the same edge
         w_acc_nxt = '0;
         w_cnt_nxt = '0;
      end else begin
         case (w_trans)
            CW: begin
               if (w_acc_up == L_SPD) begin
                  w_acc_nxt  = '0;
                  w_step_nxt = 1'b1;
                  w_dir_nxt  = 1'b1;
                  if (r_count == L_CNT_MAX)
                     w_cnt_nxt = (WRAP != 0) ? '0 : r_count;
                  else
                     w_cnt_nxt = r_count + 1'b1;
               end else begin
                  w_acc_nxt = w_acc_up;
               end
            end
            CCW: begin
               if (w_acc_dn == -L_SPD) begin
                  w_acc_nxt  = '0;
                  w_step_nxt = 1'b1;
                  w_dir_nxt  = 1'b0;
                  if (r_count == '0)
                     w_cnt_nxt = (WRAP != 0) ? L_CNT_MAX : r_count;
                  else
                     w_cnt_nxt = r_count - 1'b1;
               end else begin
                  w_acc_nxt = w_acc_dn;
               end
            end
            ILLEGAL: w_acc_nxt = '0;   // lost phase: restart the detent from scratch
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // Seed the history registers with the live inputs so the first
         // cycle out of reset sees no spurious transition or press
         r_prev_ab <= w_ab;
         r_sw      <= i_enc_sw;
         r_acc     <= '0;
         r_count   <= '0;
         r_step    <= 1'b0;
         r_dir     <= 1'b0;
         r_press   <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_prev_ab <= w_ab;
         r_sw      <= i_enc_sw;
         r_acc     <= w_acc_nxt;
         r_count   <= w_cnt_nxt;
         r_step    <= w_step_nxt;
         r_dir     <= w_dir_nxt;
         r_press   <= r_sw & ~i_enc_sw;
         r_error   <= (w_trans == ILLEGAL);
      end
   end

   assign o_count = r_count;
   assign o_step  = r_step;
   assign o_dir   = r_dir;
   assign o_press = r_press;
   assign o_error = r_error;

endmodule
